// File: rtl/cond_branch_unit.sv
// Conditional branch unit: evaluates a 3-bit condition code against a bus operand and
// holds a registered branch-taken flag until the next evaluation or clear.
//
// Parameters:
//   DATA_W     operand width (8..64)
//   PIPE       0: result one cycle after CONin; 1: extra EVAL stage, result two cycles after
// Ports:
//   clk        system clock, rising edge
//   clear      synchronous active-low reset
//   IR_cond    condition code from the instruction register
//   BusMuxOut  operand under test
//   CONin      evaluate strobe, samples IR_cond and BusMuxOut
//   CONclr     synchronous clear of the branch flag
//   CONout     registered branch-taken flag
//   CON_valid  CONout holds a completed evaluation
//   busy       evaluation in flight (PIPE=1 only)
module cond_branch_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PIPE   = 0
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [2:0]        IR_cond,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              CONin,
    input  logic              CONclr,
    output logic              CONout,
    output logic              CON_valid,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

    state_e            state_q;
    logic [2:0]        cond_q;
    logic [DATA_W-1:0] operand_q;

    // Codes 000-011 keep the legacy brzr/brnz/brpl/brmi meaning.
    function automatic logic cond_eval(input logic [2:0] code, input logic [DATA_W-1:0] op);
        logic msb;
        logic zero;
        msb  = op[DATA_W-1];
        zero = (op == '0);
        unique case (code)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b010:  return !msb;
            3'b011:  return msb;
            3'b100:  return !msb && !zero;
            3'b101:  return msb || zero;
            3'b110:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q   <= StIdle;
            cond_q    <= '0;
            operand_q <= '0;
            CONout    <= 1'b0;
            CON_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (CONin) begin
            // CONin beats CONclr; the clear still drops the old flag first.
            if (CONclr) begin
                CONout <= 1'b0;
            end
            if (PIPE == 0) begin
                CONout    <= cond_eval(IR_cond, BusMuxOut);
                CON_valid <= 1'b1;
                busy      <= 1'b0;
                state_q   <= StDone;
            end else begin
                // A CONin during EVAL simply overwrites the in-flight capture.
                cond_q    <= IR_cond;
                operand_q <= BusMuxOut;
                CON_valid <= 1'b0;
                busy      <= 1'b1;
                state_q   <= StEval;
            end
        end else if (CONclr) begin
            CONout    <= 1'b0;
            CON_valid <= 1'b0;
            busy      <= 1'b0;
            state_q   <= StIdle;
        end else if (state_q == StEval) begin
            CONout    <= cond_eval(cond_q, operand_q);
            CON_valid <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StDone;
        end
    end

endmodule

// File: tb/tb_cond_branch_unit.sv
module tb_cond_branch_unit;

    logic        clk = 1'b0;
    logic        clear;

    logic [2:0]  p0_cond, p1_cond, w16_cond;
    logic [31:0] p0_op, p1_op;
    logic [15:0] w16_op;
    logic        p0_in, p0_clr, p1_in, p1_clr, w16_in, w16_clr;
    logic        p0_out, p0_valid, p0_busy;
    logic        p1_out, p1_valid, p1_busy;
    logic        w16_out, w16_valid, w16_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cond_branch_unit #(.DATA_W(32), .PIPE(0)) u_p0 (
        .clk(clk), .clear(clear), .IR_cond(p0_cond), .BusMuxOut(p0_op), .CONin(p0_in),
        .CONclr(p0_clr), .CONout(p0_out), .CON_valid(p0_valid), .busy(p0_busy)
    );

    cond_branch_unit #(.DATA_W(32), .PIPE(1)) u_p1 (
        .clk(clk), .clear(clear), .IR_cond(p1_cond), .BusMuxOut(p1_op), .CONin(p1_in),
        .CONclr(p1_clr), .CONout(p1_out), .CON_valid(p1_valid), .busy(p1_busy)
    );

    cond_branch_unit #(.DATA_W(16), .PIPE(0)) u_w16 (
        .clk(clk), .clear(clear), .IR_cond(w16_cond), .BusMuxOut(w16_op), .CONin(w16_in),
        .CONclr(w16_clr), .CONout(w16_out), .CON_valid(w16_valid), .busy(w16_busy)
    );

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        p0_cond = '0; p0_op = '0; p0_in = 0; p0_clr = 0;
        p1_cond = '0; p1_op = '0; p1_in = 0; p1_clr = 0;
        w16_cond = '0; w16_op = '0; w16_in = 0; w16_clr = 0;
        tick(); tick(); tick();
        clear = 1'b1;
        tick();
        n_tests++;
        if ({p0_out, p0_valid, p0_busy} !== 3'b000) begin
            n_fail++; $display("FAIL reset_p0 got=%b exp=000", {p0_out, p0_valid, p0_busy});
        end
        n_tests++;
        if ({p1_out, p1_valid, p1_busy} !== 3'b000) begin
            n_fail++; $display("FAIL reset_p1 got=%b exp=000", {p1_out, p1_valid, p1_busy});
        end
        n_tests++;
        if ({w16_out, w16_valid, w16_busy} !== 3'b000) begin
            n_fail++; $display("FAIL reset_w16 got=%b exp=000", {w16_out, w16_valid, w16_busy});
        end
    endtask

    task automatic test_basic();
        p0_cond = 3'b000; p0_op = 32'h0000_0000; p0_in = 1;
        tick();
        p0_in = 0;
        n_tests++;
        if ({p0_out, p0_valid, p0_busy} !== 3'b110) begin
            n_fail++; $display("FAIL basic_zero got=%b exp=110", {p0_out, p0_valid, p0_busy});
        end
        // Input changes without CONin must not disturb the held flag.
        p0_op = 32'h0000_0001;
        tick(); tick();
        n_tests++;
        if ({p0_out, p0_valid} !== 2'b11) begin
            n_fail++; $display("FAIL basic_hold got=%b exp=11", {p0_out, p0_valid});
        end
        p0_in = 1;
        tick();
        p0_in = 0;
        n_tests++;
        if ({p0_out, p0_valid} !== 2'b01) begin
            n_fail++; $display("FAIL basic_nonzero got=%b exp=01", {p0_out, p0_valid});
        end
    endtask

    task automatic test_table();
        logic [31:0] ops [4];
        logic [3:0]  exp_tab [8];
        ops[0] = 32'h0000_0000; ops[1] = 32'h0000_0005;
        ops[2] = 32'h8000_0000; ops[3] = 32'hFFFF_FFFF;
        // Bit j = expected result for ops[j].
        exp_tab[0] = 4'b0001; exp_tab[1] = 4'b1110;
        exp_tab[2] = 4'b0011; exp_tab[3] = 4'b1100;
        exp_tab[4] = 4'b0010; exp_tab[5] = 4'b1101;
        exp_tab[6] = 4'b1111; exp_tab[7] = 4'b0000;
        for (int c = 0; c < 8; c++) begin
            for (int j = 0; j < 4; j++) begin
                p0_cond = 3'(c); p0_op = ops[j]; p0_in = 1;
                tick();
                p0_in = 0;
                n_tests++;
                if (p0_out !== exp_tab[c][j] || p0_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL table code=%0d op=%h got=%b/%b exp=%b/1", c, ops[j],
                             p0_out, p0_valid, exp_tab[c][j]);
                end
            end
        end
    endtask

    task automatic test_pipe_latency();
        p1_cond = 3'b110; p1_op = 32'h0; p1_in = 1;
        tick();
        p1_in = 0;
        n_tests++;
        if ({p1_out, p1_valid, p1_busy} !== 3'b001) begin
            n_fail++; $display("FAIL pipe_eval got=%b exp=001", {p1_out, p1_valid, p1_busy});
        end
        tick();
        n_tests++;
        if ({p1_out, p1_valid, p1_busy} !== 3'b110) begin
            n_fail++; $display("FAIL pipe_done got=%b exp=110", {p1_out, p1_valid, p1_busy});
        end
    endtask

    task automatic test_back_to_back();
        p1_cond = 3'b011; p1_op = 32'hFFFF_FFFF; p1_in = 1;
        tick();
        n_tests++;
        if ({p1_out, p1_valid, p1_busy} !== 3'b101) begin
            n_fail++; $display("FAIL b2b_n1 got=%b exp=101", {p1_out, p1_valid, p1_busy});
        end
        p1_op = 32'h0000_0001;
        tick();
        p1_in = 0;
        n_tests++;
        if ({p1_out, p1_valid, p1_busy} !== 3'b101) begin
            n_fail++; $display("FAIL b2b_n2 got=%b exp=101", {p1_out, p1_valid, p1_busy});
        end
        tick();
        n_tests++;
        if ({p1_out, p1_valid, p1_busy} !== 3'b010) begin
            n_fail++; $display("FAIL b2b_n3 got=%b exp=010", {p1_out, p1_valid, p1_busy});
        end
    endtask

    task automatic test_conclr();
        // Set the flag, then CONclr+CONin together: flag drops during EVAL, then returns.
        p1_cond = 3'b110; p1_in = 1;
        tick();
        p1_in = 0;
        tick();
        p1_clr = 1; p1_in = 1;
        tick();
        p1_clr = 0; p1_in = 0;
        n_tests++;
        if ({p1_out, p1_valid, p1_busy} !== 3'b001) begin
            n_fail++; $display("FAIL clr_in_eval got=%b exp=001", {p1_out, p1_valid, p1_busy});
        end
        tick();
        n_tests++;
        if ({p1_out, p1_valid, p1_busy} !== 3'b110) begin
            n_fail++; $display("FAIL clr_in_done got=%b exp=110", {p1_out, p1_valid, p1_busy});
        end
        p1_clr = 1;
        tick();
        p1_clr = 0;
        n_tests++;
        if ({p1_out, p1_valid, p1_busy} !== 3'b000) begin
            n_fail++; $display("FAIL clr_alone_p1 got=%b exp=000", {p1_out, p1_valid, p1_busy});
        end
        p0_cond = 3'b110; p0_in = 1;
        tick();
        p0_in = 0; p0_clr = 1;
        tick();
        p0_clr = 0;
        n_tests++;
        if ({p0_out, p0_valid, p0_busy} !== 3'b000) begin
            n_fail++; $display("FAIL clr_alone_p0 got=%b exp=000", {p0_out, p0_valid, p0_busy});
        end
    endtask

    task automatic test_width16();
        logic [31:0] wide;
        w16_cond = 3'b011; w16_op = 16'h8000; w16_in = 1;
        tick();
        w16_in = 0;
        n_tests++;
        if ({w16_out, w16_valid} !== 2'b11) begin
            n_fail++; $display("FAIL w16_msb got=%b exp=11", {w16_out, w16_valid});
        end
        wide = 32'h0001_0000;
        w16_cond = 3'b001; w16_op = wide[15:0]; w16_in = 1;
        tick();
        w16_in = 0;
        n_tests++;
        if ({w16_out, w16_valid} !== 2'b01) begin
            n_fail++; $display("FAIL w16_trunc got=%b exp=01", {w16_out, w16_valid});
        end
    endtask

    task automatic test_clear_mid_eval();
        p1_cond = 3'b110; p1_op = 32'h0; p1_in = 1;
        tick();
        p1_in = 0;
        n_tests++;
        if (p1_busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_eval_busy got=%b exp=1", p1_busy);
        end
        clear = 0;
        tick();
        clear = 1;
        n_tests++;
        if ({p1_out, p1_valid, p1_busy} !== 3'b000) begin
            n_fail++; $display("FAIL rst_eval_now got=%b exp=000", {p1_out, p1_valid, p1_busy});
        end
        tick(); tick();
        n_tests++;
        if ({p1_out, p1_valid, p1_busy} !== 3'b000) begin
            n_fail++; $display("FAIL rst_eval_late got=%b exp=000", {p1_out, p1_valid, p1_busy});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_table();
        test_pipe_latency();
        test_back_to_back();
        test_conclr();
        test_width16();
        test_clear_mid_eval();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
